// File: rtl/adiabatic_pclk_gen_if.sv
// Bus between the 4-phase power-clock sequencer and its consumer (ramp DAC / driver array).
// The sequencer is the master: it samples the run request and drives the ramp codes.
interface adiabatic_pclk_gen_if #(
    parameter int unsigned RAMP_BITS = 3
) ();

    logic                     en;
    logic [4*RAMP_BITS-1:0]   pos_code;
    logic [4*RAMP_BITS-1:0]   neg_code;
    logic [3:0]               active;
    logic                     busy;
    logic                     period_tick;

    modport master (
        input  en,
        output pos_code,
        output neg_code,
        output active,
        output busy,
        output period_tick
    );

    modport slave (
        output en,
        input  pos_code,
        input  neg_code,
        input  active,
        input  busy,
        input  period_tick
    );

endinterface

// File: rtl/adiabatic_pclk_gen.sv
// Sequencer for the 4-phase trapezoidal power clocks of adiabatic gate cells.
// Each phase walks RISE -> HOLD -> FALL -> WAIT, one segment (MAX steps) each, and the phases
// are staggered by one segment. Phases only join or leave at the start of their own RISE, so
// start-up and drain never truncate a trapezoid.
module adiabatic_pclk_gen #(
    parameter int unsigned RAMP_BITS = 3,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    adiabatic_pclk_gen_if.master bus
);

    localparam int unsigned MaxCode = (1 << RAMP_BITS) - 1;
    localparam int unsigned PcW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [RAMP_BITS-1:0] MaxC     = RAMP_BITS'(MaxCode);
    localparam logic [RAMP_BITS-1:0] LastStep = RAMP_BITS'(MaxCode - 1);
    localparam logic [PcW-1:0]       LastPc   = PcW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    state_e               state_q, state_d;
    logic [PcW-1:0]       pc_q, pc_d;
    logic [RAMP_BITS-1:0] s_q, s_d;
    logic [1:0]           seg_q, seg_d;
    logic [3:0]           active_q, active_d;
    logic                 tick_q, tick_d;

    logic                 step_end;
    logic                 seg_end;
    logic                 drain_done;
    logic [1:0]           seg_nxt;

    logic [4*RAMP_BITS-1:0] pos_flat;
    logic [4*RAMP_BITS-1:0] neg_flat;
    logic [1:0]             lseg;
    logic [RAMP_BITS-1:0]   code;

    assign step_end   = (pc_q == LastPc);
    assign seg_end    = step_end && (s_q == LastStep);
    assign drain_done = (state_q == StDrain) && (active_q == 4'b0000);
    assign seg_nxt    = seg_q + 2'd1;

    // State and counter registers; reset wins over everything, including mid-ramp.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            s_q      <= '0;
            seg_q    <= '0;
            active_q <= '0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            s_q      <= s_d;
            seg_q    <= seg_d;
            active_q <= active_d;
            tick_q   <= tick_d;
        end
    end

    // FSM next state: an empty active mask ends the drain even if en has come back.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.en) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!bus.en) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (drain_done) begin
                    state_d = StIdle;
                end else if (bus.en) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Counters and active mask; mask edits happen only where a phase enters RISE.
    always_comb begin
        pc_d     = pc_q;
        s_d      = s_q;
        seg_d    = seg_q;
        active_d = active_q;
        tick_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                pc_d     = '0;
                s_d      = '0;
                seg_d    = '0;
                active_d = bus.en ? 4'b0001 : 4'b0000;
            end
            StRun, StDrain: begin
                if (drain_done) begin
                    pc_d  = '0;
                    s_d   = '0;
                    seg_d = '0;
                end else if (step_end) begin
                    pc_d = '0;
                    s_d  = s_q + RAMP_BITS'(1);
                    if (seg_end) begin
                        s_d   = '0;
                        seg_d = seg_nxt;
                        // The phase whose local segment becomes RISE joins in RUN, leaves in DRAIN.
                        active_d[seg_nxt] = (state_q == StRun);
                        tick_d            = (seg_q == 2'd3);
                    end
                end else begin
                    pc_d = pc_q + PcW'(1);
                end
            end
            default: begin
                pc_d     = '0;
                s_d      = '0;
                seg_d    = '0;
                active_d = '0;
            end
        endcase
    end

    // Ramp codes per phase from its local segment; neg is always the complement of pos.
    always_comb begin
        pos_flat = '0;
        neg_flat = '0;
        lseg     = '0;
        code     = '0;
        for (int k = 0; k < 4; k++) begin
            lseg = seg_q - 2'(k);
            code = '0;
            if (active_q[k]) begin
                unique case (lseg)
                    2'd0: code = s_q + RAMP_BITS'(1);
                    2'd1: code = MaxC;
                    2'd2: code = LastStep - s_q;
                    2'd3: code = '0;
                    default: code = '0;
                endcase
            end
            pos_flat[k*RAMP_BITS +: RAMP_BITS] = code;
            neg_flat[k*RAMP_BITS +: RAMP_BITS] = MaxC - code;
        end
    end

    assign bus.pos_code    = pos_flat;
    assign bus.neg_code    = neg_flat;
    assign bus.active      = active_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.period_tick = tick_q;

endmodule

// File: tb/tb_adiabatic_pclk_gen.sv
// Bench for adiabatic_pclk_gen: two instances (PRESCALE 1 and 3, RAMP_BITS 2) share clk/rst/en.
// The reference model tracks elapsed cycles since RUN entry and derives each phase's code from
// its position within the 4*MAX-step trapezoid period.
module tb_adiabatic_pclk_gen;

    localparam int RB   = 2;
    localparam int MAXC = 3;
    localparam int W    = 4 * RB;

    logic clk = 1'b0;
    logic rst;
    logic en;

    always #5 clk = ~clk;

    adiabatic_pclk_gen_if #(.RAMP_BITS(RB)) if_a ();
    adiabatic_pclk_gen_if #(.RAMP_BITS(RB)) if_b ();

    assign if_a.en = en;
    assign if_b.en = en;

    adiabatic_pclk_gen #(.RAMP_BITS(RB), .PRESCALE(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.master)
    );

    adiabatic_pclk_gen #(.RAMP_BITS(RB), .PRESCALE(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.master)
    );

    int tests = 0;
    int fails = 0;

    // model: mode 0 idle, 1 run, 2 drain
    int         m_mode[2];
    int         m_cyc[2];
    logic [3:0] m_act[2];
    logic       m_tick[2];
    int         ps[2] = '{1, 3};
    int         prev_pos[2][4];
    int         exp0[12] = '{1, 2, 3, 3, 3, 3, 2, 1, 0, 0, 0, 0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int c;
        int per;
        for (int d = 0; d < 2; d++) begin
            per = 4 * MAXC * ps[d];
            if (rst) begin
                m_mode[d] = 0;
                m_cyc[d]  = 0;
                m_act[d]  = 4'b0000;
                m_tick[d] = 1'b0;
            end else if (m_mode[d] == 0) begin
                m_tick[d] = 1'b0;
                if (en) begin
                    m_mode[d] = 1;
                    m_cyc[d]  = 0;
                    m_act[d]  = 4'b0001;
                end
            end else if (m_mode[d] == 2 && m_act[d] == 4'b0000) begin
                m_mode[d] = 0;
                m_cyc[d]  = 0;
                m_tick[d] = 1'b0;
            end else begin
                c = m_cyc[d] + 1;
                m_tick[d] = ((c % per) == 0);
                if ((c % (MAXC * ps[d])) == 0) begin
                    m_act[d][(c / (MAXC * ps[d])) % 4] = (m_mode[d] == 1);
                end
                m_mode[d] = en ? 1 : 2;
                m_cyc[d]  = c % per;
            end
        end
    endtask

    function automatic int exp_pos(int d, int k);
        int n;
        int p;
        if (!m_act[d][k]) return 0;
        n = m_cyc[d] / ps[d];
        p = (n - k * MAXC + 4 * MAXC) % (4 * MAXC);
        if (p < MAXC) return p + 1;
        if (p < 2 * MAXC) return MAXC;
        if (p < 3 * MAXC) return 3 * MAXC - 1 - p;
        return 0;
    endfunction

    function automatic logic [31:0] slice(logic [W-1:0] v, int k);
        logic [31:0] r;
        r = '0;
        r[RB-1:0] = v[k*RB +: RB];
        return r;
    endfunction

    task automatic check_all();
        logic [W-1:0] pv;
        logic [W-1:0] nv;
        logic [3:0]   av;
        logic         bv;
        logic         tv;
        logic [31:0]  gp;
        int           ep;
        string        nm;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                pv = if_a.pos_code; nv = if_a.neg_code; av = if_a.active;
                bv = if_a.busy;     tv = if_a.period_tick; nm = "a";
            end else begin
                pv = if_b.pos_code; nv = if_b.neg_code; av = if_b.active;
                bv = if_b.busy;     tv = if_b.period_tick; nm = "b";
            end
            for (int k = 0; k < 4; k++) begin
                ep = exp_pos(d, k);
                gp = slice(pv, k);
                chk($sformatf("%s.pos%0d", nm, k), gp, ep);
                chk($sformatf("%s.neg%0d", nm, k), slice(nv, k), MAXC - ep);
                if (prev_pos[d][k] == 0 && gp != 0) begin
                    chk($sformatf("%s.rise_start%0d", nm, k), gp, 1);
                end
                prev_pos[d][k] = int'(gp);
            end
            chk($sformatf("%s.active", nm), 32'(av), 32'(m_act[d]));
            chk($sformatf("%s.busy", nm), 32'(bv), (m_mode[d] != 0) ? 1 : 0);
            chk($sformatf("%s.tick", nm), 32'(tv), 32'(m_tick[d]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".a.pos"}, 32'(if_a.pos_code), 0);
        chk({tag, ".a.neg"}, 32'(if_a.neg_code), 32'hFF);
        chk({tag, ".a.busy"}, 32'(if_a.busy), 0);
        chk({tag, ".b.neg"}, 32'(if_b.neg_code), 32'hFF);
        chk({tag, ".b.tick"}, 32'(if_b.period_tick), 0);
    endtask

    initial begin
        int t0;
        int t1;
        int len;
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_cyc[d] = 0; m_act[d] = '0; m_tick[d] = 1'b0;
            for (int k = 0; k < 4; k++) prev_pos[d][k] = 0;
        end
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) cycle();
        chk_reset_values("reset");
        rst = 1'b0;
        cycle();

        // Start-up: phase 0 waveform, phase 1 delay, staggered activation, tick period.
        en = 1'b1;
        t0 = -1;
        t1 = -1;
        for (int i = 0; i < 92; i++) begin
            cycle();
            if (i < 12) begin
                chk("seq.p0", slice(if_a.pos_code, 0), exp0[i]);
                chk("seq.p1", slice(if_a.pos_code, 1), (i >= 3) ? exp0[i-3] : 0);
                chk("seq.act", 32'(if_a.active), (i < 3) ? 1 : (i < 6) ? 3 : (i < 9) ? 7 : 15);
            end
            if (if_b.period_tick) begin
                if (t0 < 0) t0 = i;
                else if (t1 < 0) t1 = i;
            end
        end
        chk("tick.first_b", t0, 36);
        chk("tick.period_b", t1 - t0, 36);

        // Drain after RUN cycle 14.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 14; i++) cycle();
        en = 1'b0;
        for (int i = 0; i < 60; i++) cycle();
        chk_reset_values("drain");
        chk("drain.b.busy", 32'(if_b.busy), 0);
        chk("drain.b.pos", 32'(if_b.pos_code), 0);

        // Re-enable in the middle of a drain.
        en = 1'b1;
        for (int i = 0; i < 30; i++) cycle();
        en = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        en = 1'b1;
        for (int i = 0; i < 40; i++) cycle();

        // Reset while phase 0 of dut_a is in HOLD, with en held high.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        rst = 1'b1;
        cycle();
        chk_reset_values("midhold");
        rst = 1'b0;
        cycle();
        chk("restart.p0", slice(if_a.pos_code, 0), 1);
        chk("restart.act", 32'(if_a.active), 1);

        // Randomized en run lengths with occasional reset.
        for (int r = 0; r < 60; r++) begin
            len = $urandom_range(1, 40);
            en  = 1'($urandom_range(0, 1));
            for (int j = 0; j < len; j++) begin
                rst = ($urandom_range(0, 99) == 0);
                cycle();
            end
        end
        rst = 1'b0;
        en  = 1'b0;
        for (int i = 0; i < 60; i++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
